// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default element width and a signed max helper.
package cnn_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] pix_t;

    // Signed two's-complement maximum; on a tie either operand is the same value.
    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one horizontal-max value per 2-pixel column pair.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write; rd_addr/rd_data
// asynchronous read. Contents are not reset: every entry is written on an
// even row before the following odd row reads it.
module pool_line_buf #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AW         = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order feature map.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready input stream;
// out_valid/out_data/out_last/out_ready output stream. in_ready is
// combinational: the only stall is a held, unconsumed result.
// The max datapath uses the cnn_pkg element width (DATA_WIDTH default).
module maxpool_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int unsigned COL_W    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic                  in_fire;
    logic                  lb_we;
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] lb_wdata;
    logic [DATA_WIDTH-1:0] lb_rdata;

    assign in_ready = !(out_valid_q && !out_ready);
    assign in_fire  = in_valid && in_ready;
    assign lb_addr  = LB_AW'(col_q >> 1);

    pool_line_buf #(
        .DEPTH      (LB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (lb_wdata),
        .rd_addr (lb_addr),
        .rd_data (lb_rdata)
    );

    // Window position decode, counters and result load.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lb_we       = 1'b0;
        // Horizontal pair max: line-buffer write on even rows, result on odd rows.
        lb_wdata    = DATA_WIDTH'(smax(pix_t'(h_q), pix_t'(in_data)));

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            unique case ({row_q[0], col_q[0]})
                2'b00: h_d = in_data;
                2'b01: lb_we = 1'b1;
                2'b10: h_d = DATA_WIDTH'(smax(pix_t'(lb_rdata), pix_t'(in_data)));
                default: begin
                    // Load wins over a same-cycle drain, keeping out_valid high.
                    out_data_d  = lb_wdata;
                    out_valid_d = 1'b1;
                    out_last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: a 4x4 instance for directed frames and an 8x8
// instance (default geometry) for randomized handshake streaming.
module tb_maxpool_stream;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready;
    logic [15:0] b_in_data, b_out_data;

    exp_t qa[$];
    exp_t qb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   a_n_out  = 0;
    int   b_n_out  = 0;

    maxpool_stream #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(a_out_ready)
    );

    maxpool_stream #(.DATA_WIDTH(16), .IMG_W(8), .IMG_H(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: 2x2 window maxima in raster order, last on the final window.
    task automatic model(input int w, input int h, input int px[$], input bit to_b);
        exp_t e;
        int   m;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                m = px[r*w + c];
                if (px[r*w + c + 1] > m)     m = px[r*w + c + 1];
                if (px[(r+1)*w + c] > m)     m = px[(r+1)*w + c];
                if (px[(r+1)*w + c + 1] > m) m = px[(r+1)*w + c + 1];
                e.d = 16'(m);
                e.l = (r == h - 2) && (c == w - 2);
                if (to_b) qb.push_back(e);
                else      qa.push_back(e);
            end
        end
    endtask

    // Output monitors: a transfer is decided by the values present before the edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            a_n_out++;
            check("a_queue_nonempty", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_out_data", 32'(a_out_data), 32'(e.d));
                check("a_out_last", 32'(a_out_last), 32'(e.l));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            b_n_out++;
            check("b_queue_nonempty", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_out_data", 32'(b_out_data), 32'(e.d));
                check("b_out_last", 32'(b_out_last), 32'(e.l));
            end
        end
    end

    // Present one pixel on stream A and wait (bounded) for its transfer.
    task automatic send_a(input int v);
        bit done;
        done = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 16'(v);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (a_in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("a_in_accept", 32'(done), 32'd1);
    endtask

    task automatic send_frame_a(input int px[$]);
        model(4, 4, px, 1'b0);
        foreach (px[i]) send_a(px[i]);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 200 && qa.size() != 0; i++) @(posedge clk);
        #1;
        check("a_drained", 32'(qa.size()), 32'd0);
    endtask

    initial begin
        int  ramp[$];
        int  neg[$];
        int  f2[$];
        int  px[$];
        int  p;
        int  guard;
        bit  fire;
        logic signed [15:0] t;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ramp.push_back(i);
            neg.push_back(-32768 + i);
            f2.push_back(200 - 7 * i);
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_out_data",  32'(a_out_data),  32'd0);
        check("rst_a_out_last",  32'(a_out_last),  32'd0);
        check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        check("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame: 5, 7, 13, 15.
        send_frame_a(ramp);
        a_in_valid = 1'b0;
        drain_a();

        // All-negative frame exercises the signed compare.
        send_frame_a(neg);
        a_in_valid = 1'b0;
        drain_a();

        // Consumer stall on the first result of a frame.
        model(4, 4, ramp, 1'b0);
        for (int i = 0; i < 5; i++) send_a(i);
        a_out_ready = 1'b0;
        send_a(5);
        a_in_valid = 1'b1;
        a_in_data  = 16'd6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(a_out_valid), 32'd1);
            check("stall_out_data",  32'(a_out_data),  32'd5);
            check("stall_in_ready",  32'(a_in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        for (int i = 6; i < 16; i++) send_a(i);
        a_in_valid = 1'b0;
        drain_a();

        // Reset mid-frame: partial frame must leave nothing behind.
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_a(1000 + i);
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_out_data",  32'(a_out_data),  32'd0);
        check("mid_rst_out_last",  32'(a_out_last),  32'd0);
        check("mid_rst_in_ready",  32'(a_in_ready),  32'd1);
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        send_frame_a(ramp);
        a_in_valid = 1'b0;
        drain_a();

        // Two frames back-to-back with in_valid never dropping.
        a_n_out = 0;
        send_frame_a(ramp);
        send_frame_a(f2);
        a_in_valid = 1'b0;
        drain_a();
        check("b2b_output_count", 32'(a_n_out), 32'd8);

        // Randomized handshakes over 100 frames on the 8x8 instance.
        for (int f = 0; f < 100; f++) begin
            px.delete();
            for (int i = 0; i < 64; i++) begin
                t = 16'($urandom);
                px.push_back(int'(t));
            end
            model(8, 8, px, 1'b1);
            p = 0;
            guard = 0;
            while (p < 64 && guard < 2000) begin
                b_in_valid  = ($urandom_range(0, 3) != 0);
                b_in_data   = 16'(px[p]);
                b_out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                fire = b_in_valid && b_in_ready;
                @(posedge clk);
                #1;
                if (fire) p++;
                guard++;
            end
            check("b_frame_accepted", 32'(p), 32'd64);
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 500 && qb.size() != 0; i++) @(posedge clk);
        #1;
        check("b_drained", 32'(qb.size()), 32'd0);
        check("b_output_count", 32'(b_n_out), 32'd1600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
